// File: rtl/muli_sequencer_pkg.sv
// ============================================================================
// muli_sequencer_pkg : shared types, defaults and fixed-point helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package muli_sequencer_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_FRAC  = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muli_state_t;

   // Clamp a signed value into the range of a WIDTH-bit two's-complement word.
   function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                   input int                 width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (val > hi)
         saturate = hi;
      else if (val < lo)
         saturate = lo;
      else
         saturate = val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/muli_sequencer_booth_step.sv
// ============================================================================
// booth_step : one combinational radix-2 Booth iteration (add/sub + shift)
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_q_m1,
   output logic [WIDTH:0]   o_acc,
   output logic [WIDTH-1:0] o_q,
   output logic             o_q_m1
);

   // One guard bit on the accumulator keeps -2^(WIDTH-1) multiplicands exact.
   logic [WIDTH:0] w_mcand_ext;
   logic [WIDTH:0] w_sum;

   assign w_mcand_ext = {i_mcand[WIDTH-1], i_mcand};

   always_comb begin
      w_sum = i_acc;
      case ({i_q[0], i_q_m1})
         2'b01:   w_sum = i_acc + w_mcand_ext;
         2'b10:   w_sum = i_acc - w_mcand_ext;
         default: w_sum = i_acc;
      endcase
   end

   assign o_acc  = {w_sum[WIDTH], w_sum[WIDTH:1]};
   assign o_q    = {w_sum[0], i_q[WIDTH-1:1]};
   assign o_q_m1 = i_q[0];

endmodule

`default_nettype wire

// File: rtl/muli_sequencer.sv
// ============================================================================
// muli_sequencer : multi-cycle MULI controller, sequential Booth multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module muli_sequencer
   import muli_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             wr_en,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   muli_state_t r_state;
   muli_state_t w_state_next;

   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_q;
   logic             r_q_m1;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_rst_q;

   logic [WIDTH:0]   w_acc_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_q_m1_next;
   logic             w_accept;
   logic             w_stall;
   logic             w_busy;
   logic             w_wr_en;

   logic signed [2*WIDTH-1:0] w_product;
   logic signed [2*WIDTH-1:0] w_shifted;
   logic signed [31:0]        w_shift_ext;
   logic [WIDTH-1:0]          w_result;

   booth_step #(.WIDTH(WIDTH)) u_booth_step (
      .i_acc   (r_acc),
      .i_mcand (r_mcand),
      .i_q     (r_q),
      .i_q_m1  (r_q_m1),
      .o_acc   (w_acc_next),
      .o_q     (w_q_next),
      .o_q_m1  (w_q_m1_next)
   );

   // The final Booth step's outputs form the full product on the DONE-entry edge.
   assign w_product   = {w_acc_next[WIDTH-1:0], w_q_next};
   assign w_shifted   = w_product >>> FRAC;
   assign w_shift_ext = 32'(w_shifted);
   assign w_result    = WIDTH'(saturate(w_shift_ext, WIDTH));

   // A start in the cycle right after reset is held off so no output can rise there.
   assign w_accept = (r_state == ST_IDLE) && start && !r_rst_q;

   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_busy       = 1'b0;
      w_wr_en      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stall = start && !r_rst_q;
            if (w_accept)
               w_state_next = ST_BUSY;
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            w_busy  = 1'b1;
            if (r_cnt == '0)
               w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_busy       = 1'b1;
            w_wr_en      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_q      <= '0;
         r_q_m1   <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_rst_q  <= 1'b1;
      end else begin
         r_rst_q <= 1'b0;
         r_state <= w_state_next;
         if (w_accept) begin
            r_mcand <= a;
            r_q     <= b;
            r_q_m1  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
         end else if (r_state == ST_BUSY) begin
            r_acc  <= w_acc_next;
            r_q    <= w_q_next;
            r_q_m1 <= w_q_m1_next;
            if (r_cnt == '0)
               r_result <= w_result;
            else
               r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign stall  = w_stall && !reset;
   assign busy   = w_busy  && !reset;
   assign wr_en  = w_wr_en && !reset;
   assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muli_sequencer.sv
// ============================================================================
// tb_muli_sequencer : scoreboard bench for the MULI sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muli_sequencer;

   localparam int WIDTH = 8;
   localparam int FRAC  = 7;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             stall;
   logic             busy;
   logic             wr_en;
   logic [WIDTH-1:0] result;

   int               n_vec;
   int               n_err;
   int               cyc;
   int               wr_prev;
   int               wr_last;
   logic [WIDTH-1:0] sb_q[$];

   muli_sequencer #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .stall  (stall),
      .busy   (busy),
      .wr_en  (wr_en),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] ia,
                                                input logic [WIDTH-1:0] ib);
      int p;
      int s;
      p = int'($signed(ia)) * int'($signed(ib));
      s = p >>> FRAC;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      ref_mul = WIDTH'(s);
   endfunction

   // Called just after each falling edge: scoreboard pop on every write strobe.
   task automatic sample();
      cyc++;
      if (wr_en) begin
         wr_prev = wr_last;
         wr_last = cyc;
         if (sb_q.size() == 0)
            check_eq("wr_unexpected", 32'(wr_en), 32'd0);
         else
            check_eq("result", 32'(result), 32'(sb_q.pop_front()));
      end
   endtask

   // Entered right after a falling edge; returns after the IDLE cycle following DONE.
   task automatic do_mul(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input bit hold, input int chg_at);
      start = 1'b1;
      a     = ia;
      b     = ib;
      sb_q.push_back(ref_mul(ia, ib));
      #1;
      check_eq("stall_c0", 32'(stall), 32'd1);
      for (int k = 1; k <= WIDTH + 1; k++) begin
         @(negedge clk);
         sample();
         check_eq("stall", 32'(stall), (k <= WIDTH) ? 32'd1 : 32'd0);
         check_eq("wr_en", 32'(wr_en), (k == WIDTH + 1) ? 32'd1 : 32'd0);
         check_eq("busy",  32'(busy), 32'd1);
         if (k == chg_at) begin
            a = '0;
            b = 8'h81;
         end
         if (k == WIDTH + 1 && !hold)
            start = 1'b0;
      end
      @(negedge clk);
      sample();
      check_eq("busy_end", 32'(busy), 32'd0);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cyc     = 0;
      wr_prev = 0;
      wr_last = 0;
      reset   = 1'b1;
      start   = 1'b0;
      a       = '0;
      b       = '0;

      repeat (3) @(negedge clk);
      sample();
      check_eq("rst_stall",  32'(stall),  32'd0);
      check_eq("rst_busy",   32'(busy),   32'd0);
      check_eq("rst_wr_en",  32'(wr_en),  32'd0);
      check_eq("rst_result", 32'(result), 32'd0);
      start = 1'b1;
      #1;
      check_eq("rst_start_stall", 32'(stall), 32'd0);
      @(negedge clk);
      sample();
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      sample();

      do_mul(8'd64, 8'd64, 1'b0, 0);
      do_mul(8'hC0, 8'd64, 1'b0, 0);
      do_mul(8'hFF, 8'd1,  1'b0, 0);
      do_mul(8'h80, 8'h80, 1'b0, 0);
      do_mul(8'd127, 8'd127, 1'b0, 0);
      check_eq("sat_hold", 32'(result), 32'h7E);

      // Reset during BUSY cycle 4: no write, everything cleared.
      start = 1'b1;
      a     = 8'd64;
      b     = 8'd64;
      repeat (4) begin
         @(negedge clk);
         sample();
      end
      reset = 1'b1;
      start = 1'b0;
      #1;
      check_eq("midrst_stall", 32'(stall), 32'd0);
      check_eq("midrst_busy",  32'(busy),  32'd0);
      @(negedge clk);
      sample();
      check_eq("postrst_stall",  32'(stall),  32'd0);
      check_eq("postrst_busy",   32'(busy),   32'd0);
      check_eq("postrst_wr_en",  32'(wr_en),  32'd0);
      check_eq("postrst_result", 32'(result), 32'd0);
      reset = 1'b0;
      start = 1'b1;
      #1;
      check_eq("postrst_start_stall", 32'(stall), 32'd0);
      @(negedge clk);
      sample();
      do_mul(8'd64, 8'd64, 1'b0, 0);

      // Back-to-back: second op starts in the IDLE cycle after DONE.
      do_mul(8'd32, 8'd4, 1'b1, 0);
      do_mul(8'd16, 8'hF8, 1'b0, 0);
      check_eq("b2b_gap", 32'(wr_last - wr_prev), 32'd10);

      do_mul(8'd64, 8'd64, 1'b0, 3);

      for (int i = 0; i < 1000; i++)
         do_mul(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 0);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
